ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 32-bit MIPS-style five-stage pipeline.
- Selects ALU operands through the forwarding muxes.
- Decodes the ALU operation from the main-control ALU op and the instruction funct field.
- Computes the result and picks the destination register.
- Registers the ALU result, store operand and destination register into the EX/MEM boundary with one-cycle latency.

Parameters:
INST_SZ, 32, datapath/instruction width
ALU_OP, 3, width of main-control ALU op code
FORW_ALU, 2, width of forwarding selects
ALU_SEL, 6, width of funct field / internal ALU control code

Ports:
i_clk  in  1  clock, rising-edge
i_rst_n  in  1  reset, asynchronous, active-low
i_read_data_1_E  in  INST_SZ  rs register value from ID/EX
i_read_data_2_E  in  INST_SZ  rt register value from ID/EX
i_alu_result_M  in  INST_SZ  ALU result in MEM stage (forward source)
i_read_data_W  in  INST_SZ  writeback data in WB stage (forward source)
i_instr_imm_D  in  INST_SZ  sign-extended 16-bit immediate; [10:6]=shamt, [5:0]=funct
i_instr_rt_D  in  5  rt field
i_instr_rd_D  in  5  rd field
i_alu_src_MC  in  1  0: ALU B = forwarded rt value; 1: ALU B = immediate
i_reg_dst_MC  in  1  0: dest = rt; 1: dest = rd
i_jal_sel_MC  in  1  1: dest = 31 (overrides reg_dst)
i_alu_op_MC  in  ALU_OP  main-control ALU op
i_forward_a_FU  in  FORW_ALU  forward select, operand A
i_forward_b_FU  in  FORW_ALU  forward select, operand B
o_alu_result_E  out  INST_SZ  registered ALU result
o_operand_b_E  out  INST_SZ  registered forwarded rt value (store data)
o_instr_rd_E  out  5  registered destination register

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low. While i_rst_n=0, all outputs are 0.
- Forwarding select, identical for A and B:
  - 00 = register value (read_data_1 for A, read_data_2 for B)
  - 01 = i_read_data_W
  - 10 = i_alu_result_M
  - 11 = register value
- Operand B: fwdB goes to o_operand_b; ALU B = alu_src ? imm : fwdB.
- Destination: jal_sel ? 5'd31 : (reg_dst ? rd : rt).
- ALU op decode:
  - 000 add (LW/SW/ADDI/ADDIU)
  - 001 sub (BEQ/BNE)
  - 010 R-type, use funct = imm[5:0]
  - 011 AND with zero-extended imm[15:0]
  - 100 OR with zero-extended imm[15:0]
  - 101 XOR with zero-extended imm[15:0]
  - 110 LUI: B[15:0] << 16
  - 111 SLTI, signed
- R-type funct map:
  - SLL 000000, SRL 000010, SRA 000011: B shifted by imm[10:6]
  - SLLV 000100, SRLV 000110, SRAV 000111: B shifted by A[4:0]
  - ADD 100000, ADDU 100001: A+B
  - SUB 100010, SUBU 100011: A-B
  - AND 100100, OR 100101, XOR 100110, NOR 100111
  - SLT 101010 (signed), SLTU 101011 (unsigned): result 32'd1 or 0
  - any other funct (incl. JR/JALR): result 0
- Arithmetic: modulo 2^32; no overflow trap; no flags output.
- Timing: all computation is combinational. On each rising i_clk with i_rst_n=1, the three outputs capture the new values, so latency is 1 cycle. There is no enable or stall.
- Reset asserted mid-operation clears outputs immediately, independent of clock. The first edge after release loads the current inputs.

Test Plan:
1. SLL: alu_op=010, reg_dst=1, alu_src=0, fwd=00, read_data_2=0x000000F1, imm=0x00002900 (rd=5, shamt=4, funct=0) -> after one edge o_alu_result=0x00000F10, o_instr_rd=5.
2. ADDU with MEM forwarding: fwdA=10, i_alu_result_M=0x10, read_data_2=0x20, imm funct=100001 (imm=0x00003821, rd=7) -> o_alu_result=0x30, o_instr_rd=7.
3. LW: alu_op=000, alu_src=1, reg_dst=0, rt=3, read_data_1=0x100, imm=0xFFFFFFFC -> o_alu_result=0xFC, o_instr_rd=3.
4. SW with WB forwarding: fwdB=01, i_read_data_W=0xDEADBEEF, alu_src=1 -> o_operand_b=0xDEADBEEF.
5. BEQ/JAL: alu_op=001, equal operands 0x55 -> o_alu_result=0. Then jal_sel=1 -> o_instr_rd=31.
6. Reset: drive nonzero outputs, pull i_rst_n low between edges -> all outputs 0 immediately. Release, then next edge -> outputs reload.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding muxes, ALU decode and compute, EX/MEM register
// Operands come through the forwarding muxes, the ALU runs combinationally, and results register on i_clk.
module ex_stage #(
   parameter int INST_SZ  = 32,
   parameter int ALU_OP   = 3,
   parameter int FORW_ALU = 2,
   parameter int ALU_SEL  = 6
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [INST_SZ-1:0]  i_read_data_1_E,
   input  logic [INST_SZ-1:0]  i_read_data_2_E,
   input  logic [INST_SZ-1:0]  i_alu_result_M,
   input  logic [INST_SZ-1:0]  i_read_data_W,
   input  logic [INST_SZ-1:0]  i_instr_imm_D,
   input  logic [4:0]          i_instr_rt_D,
   input  logic [4:0]          i_instr_rd_D,
   input  logic                i_alu_src_MC,
   input  logic                i_reg_dst_MC,
   input  logic                i_jal_sel_MC,
   input  logic [ALU_OP-1:0]   i_alu_op_MC,
   input  logic [FORW_ALU-1:0] i_forward_a_FU,
   input  logic [FORW_ALU-1:0] i_forward_b_FU,
   output logic [INST_SZ-1:0]  o_alu_result_E,
   output logic [INST_SZ-1:0]  o_operand_b_E,
   output logic [4:0]          o_instr_rd_E
);

   localparam logic [ALU_OP-1:0] OP_ADD  = 3'b000;
   localparam logic [ALU_OP-1:0] OP_SUB  = 3'b001;
   localparam logic [ALU_OP-1:0] OP_RTYP = 3'b010;
   localparam logic [ALU_OP-1:0] OP_ANDI = 3'b011;
   localparam logic [ALU_OP-1:0] OP_ORI  = 3'b100;
   localparam logic [ALU_OP-1:0] OP_XORI = 3'b101;
   localparam logic [ALU_OP-1:0] OP_LUI  = 3'b110;
   localparam logic [ALU_OP-1:0] OP_SLTI = 3'b111;

   localparam logic [ALU_SEL-1:0] C_SLL  = 6'b000000;
   localparam logic [ALU_SEL-1:0] C_SRL  = 6'b000010;
   localparam logic [ALU_SEL-1:0] C_SRA  = 6'b000011;
   localparam logic [ALU_SEL-1:0] C_SLLV = 6'b000100;
   localparam logic [ALU_SEL-1:0] C_SRLV = 6'b000110;
   localparam logic [ALU_SEL-1:0] C_SRAV = 6'b000111;
   localparam logic [ALU_SEL-1:0] C_LUI  = 6'b001111;
   localparam logic [ALU_SEL-1:0] C_ADD  = 6'b100000;
   localparam logic [ALU_SEL-1:0] C_ADDU = 6'b100001;
   localparam logic [ALU_SEL-1:0] C_SUB  = 6'b100010;
   localparam logic [ALU_SEL-1:0] C_SUBU = 6'b100011;
   localparam logic [ALU_SEL-1:0] C_AND  = 6'b100100;
   localparam logic [ALU_SEL-1:0] C_OR   = 6'b100101;
   localparam logic [ALU_SEL-1:0] C_XOR  = 6'b100110;
   localparam logic [ALU_SEL-1:0] C_NOR  = 6'b100111;
   localparam logic [ALU_SEL-1:0] C_SLT  = 6'b101010;
   localparam logic [ALU_SEL-1:0] C_SLTU = 6'b101011;
   localparam logic [ALU_SEL-1:0] C_NONE = 6'b111111;

   localparam logic [FORW_ALU-1:0] FW_WB  = 2'b01;
   localparam logic [FORW_ALU-1:0] FW_MEM = 2'b10;

   logic [INST_SZ-1:0] alu_result_d, alu_result_q;
   logic [INST_SZ-1:0] operand_b_d, operand_b_q;
   logic [4:0]         instr_rd_d, instr_rd_q;

   logic [INST_SZ-1:0] fwd_a, fwd_b, alu_b, imm_zext;
   logic [ALU_SEL-1:0] alu_ctrl;
   logic               use_zext;
   logic [4:0]         shamt, shvar;

   function automatic logic [INST_SZ-1:0] fwd_mux(
      input logic [FORW_ALU-1:0] sel,
      input logic [INST_SZ-1:0]  reg_val,
      input logic [INST_SZ-1:0]  wb_val,
      input logic [INST_SZ-1:0]  mem_val
   );
      logic [INST_SZ-1:0] r;
      case (sel)
         FW_WB:   r = wb_val;
         FW_MEM:  r = mem_val;
         default: r = reg_val;
      endcase
      return r;
   endfunction

   always_comb begin
      fwd_a    = fwd_mux(i_forward_a_FU, i_read_data_1_E, i_read_data_W, i_alu_result_M);
      fwd_b    = fwd_mux(i_forward_b_FU, i_read_data_2_E, i_read_data_W, i_alu_result_M);
      alu_b    = i_alu_src_MC ? i_instr_imm_D : fwd_b;
      imm_zext = {{(INST_SZ-16){1'b0}}, i_instr_imm_D[15:0]};
      shamt    = i_instr_imm_D[10:6];
      shvar    = fwd_a[4:0];
   end

   // Main-control op and funct fold into one control code; C_LUI is never a legal R-type pass-through.
   always_comb begin
      alu_ctrl = C_NONE;
      use_zext = 1'b0;
      case (i_alu_op_MC)
         OP_ADD:  alu_ctrl = C_ADDU;
         OP_SUB:  alu_ctrl = C_SUBU;
         OP_RTYP: begin
            case (i_instr_imm_D[ALU_SEL-1:0])
               C_SLL, C_SRL, C_SRA, C_SLLV, C_SRLV, C_SRAV,
               C_ADD, C_ADDU, C_SUB, C_SUBU, C_AND, C_OR,
               C_XOR, C_NOR, C_SLT, C_SLTU:
                  alu_ctrl = i_instr_imm_D[ALU_SEL-1:0];
               default: alu_ctrl = C_NONE;
            endcase
         end
         OP_ANDI: begin alu_ctrl = C_AND; use_zext = 1'b1; end
         OP_ORI:  begin alu_ctrl = C_OR;  use_zext = 1'b1; end
         OP_XORI: begin alu_ctrl = C_XOR; use_zext = 1'b1; end
         OP_LUI:  alu_ctrl = C_LUI;
         OP_SLTI: alu_ctrl = C_SLT;
         default: alu_ctrl = C_NONE;
      endcase
   end

   always_comb begin
      logic [INST_SZ-1:0] b_eff;
      b_eff        = use_zext ? imm_zext : alu_b;
      alu_result_d = '0;
      case (alu_ctrl)
         C_SLL:         alu_result_d = b_eff << shamt;
         C_SRL:         alu_result_d = b_eff >> shamt;
         C_SRA:         alu_result_d = $signed(b_eff) >>> shamt;
         C_SLLV:        alu_result_d = b_eff << shvar;
         C_SRLV:        alu_result_d = b_eff >> shvar;
         C_SRAV:        alu_result_d = $signed(b_eff) >>> shvar;
         C_LUI:         alu_result_d = {b_eff[15:0], {(INST_SZ-16){1'b0}}};
         C_ADD, C_ADDU: alu_result_d = fwd_a + b_eff;
         C_SUB, C_SUBU: alu_result_d = fwd_a - b_eff;
         C_AND:         alu_result_d = fwd_a & b_eff;
         C_OR:          alu_result_d = fwd_a | b_eff;
         C_XOR:         alu_result_d = fwd_a ^ b_eff;
         C_NOR:         alu_result_d = ~(fwd_a | b_eff);
         C_SLT:         alu_result_d = {{(INST_SZ-1){1'b0}}, ($signed(fwd_a) < $signed(b_eff))};
         C_SLTU:        alu_result_d = {{(INST_SZ-1){1'b0}}, (fwd_a < b_eff)};
         default:       alu_result_d = '0;
      endcase
   end

   always_comb begin
      operand_b_d = fwd_b;
      if (i_jal_sel_MC)      instr_rd_d = 5'd31;
      else if (i_reg_dst_MC) instr_rd_d = i_instr_rd_D;
      else                   instr_rd_d = i_instr_rt_D;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         alu_result_q <= '0;
         operand_b_q  <= '0;
         instr_rd_q   <= '0;
      end else begin
         alu_result_q <= alu_result_d;
         operand_b_q  <= operand_b_d;
         instr_rd_q   <= instr_rd_d;
      end
   end

   assign o_alu_result_E = alu_result_q;
   assign o_operand_b_E  = operand_b_q;
   assign o_instr_rd_E   = instr_rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
// Directed vector table, reset sequence, then random stimulus against a behavioural model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rd1, rd2, res_m, rd_w, imm;
   logic [4:0]  rt, rd;
   logic        alu_src, reg_dst, jal_sel;
   logic [2:0]  alu_op;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] o_res, o_opb;
   logic [4:0]  o_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_read_data_1_E(rd1), .i_read_data_2_E(rd2),
      .i_alu_result_M(res_m), .i_read_data_W(rd_w),
      .i_instr_imm_D(imm), .i_instr_rt_D(rt), .i_instr_rd_D(rd),
      .i_alu_src_MC(alu_src), .i_reg_dst_MC(reg_dst), .i_jal_sel_MC(jal_sel),
      .i_alu_op_MC(alu_op), .i_forward_a_FU(fwd_a), .i_forward_b_FU(fwd_b),
      .o_alu_result_E(o_res), .o_operand_b_E(o_opb), .o_instr_rd_E(o_rd)
   );

   typedef struct {
      string       name;
      logic [31:0] a, b, m, w, imm;
      logic [4:0]  rt, rd;
      logic        src, dst, jal;
      logic [2:0]  op;
      logic [1:0]  fa, fb;
      logic [31:0] exp_res, exp_opb;
      logic [4:0]  exp_rd;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rd1 = v.a; rd2 = v.b; res_m = v.m; rd_w = v.w; imm = v.imm;
      rt = v.rt; rd = v.rd; alu_src = v.src; reg_dst = v.dst; jal_sel = v.jal;
      alu_op = v.op; fwd_a = v.fa; fwd_b = v.fb;
   endtask

   task automatic check_vec(input vec_t v);
      check({v.name, ".res"}, o_res, v.exp_res);
      check({v.name, ".opb"}, o_opb, v.exp_opb);
      check({v.name, ".rd"}, {27'd0, o_rd}, {27'd0, v.exp_rd});
   endtask

   function automatic vec_t mk(input string name, input logic [31:0] a, b, m, w, im,
                               input logic [4:0] t, d, input logic s, ds, j,
                               input logic [2:0] op, input logic [1:0] fa, fb,
                               input logic [31:0] er, eo, input logic [4:0] ed);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.m = m; v.w = w; v.imm = im;
      v.rt = t; v.rd = d; v.src = s; v.dst = ds; v.jal = j; v.op = op;
      v.fa = fa; v.fb = fb; v.exp_res = er; v.exp_opb = eo; v.exp_rd = ed;
      return v;
   endfunction

   // Behavioural reference: result straight from the instruction-set rules.
   function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] im);
      logic [31:0] z;
      int unsigned sa, sv;
      z  = im & 32'h0000FFFF;
      sa = int'(im[10:6]);
      sv = a % 32;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd3: return a & z;
         3'd4: return a | z;
         3'd5: return a ^ z;
         3'd6: return (b % 65536) * 65536;
         3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         default: begin
            case (im[5:0])
               6'd0:  return b << sa;
               6'd2:  return b >> sa;
               6'd3:  return 32'(int'(b) >>> sa);
               6'd4:  return b << sv;
               6'd6:  return b >> sv;
               6'd7:  return 32'(int'(b) >>> sv);
               6'd32, 6'd33: return a + b;
               6'd34, 6'd35: return a - b;
               6'd36: return a & b;
               6'd37: return a | b;
               6'd38: return a ^ b;
               6'd39: return ~(a | b);
               6'd42: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
               6'd43: return (a < b) ? 32'd1 : 32'd0;
               default: return 32'd0;
            endcase
         end
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] w, input logic [31:0] m);
      if (s == 2'd1) return w;
      if (s == 2'd2) return m;
      return r;
   endfunction

   logic [5:0] legal_f[16] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd33,
                               6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};

   initial begin
      //           name     a            b            m            w            imm          rt  rd src dst jal op    fa    fb     exp_res       exp_opb       rd
      vecs[0]  = mk("sll",   32'h0,       32'hF1,      32'h0,       32'h0,       32'h2900,    0,  5, 0, 1, 0, 3'd2, 2'd0, 2'd0, 32'hF10,      32'hF1,       5);
      vecs[1]  = mk("addu_m",32'h0,       32'h20,      32'h10,      32'h0,       32'h3821,    0,  7, 0, 1, 0, 3'd2, 2'd2, 2'd0, 32'h30,       32'h20,       7);
      vecs[2]  = mk("lw",    32'h100,     32'h0,       32'h0,       32'h0,       32'hFFFFFFFC,3,  9, 1, 0, 0, 3'd0, 2'd0, 2'd0, 32'hFC,       32'h0,        3);
      vecs[3]  = mk("sw_w",  32'h200,     32'h1,       32'h0,       32'hDEADBEEF,32'h8,       4,  0, 1, 0, 0, 3'd0, 2'd0, 2'd1, 32'h208,      32'hDEADBEEF, 4);
      vecs[4]  = mk("beq",   32'h55,      32'h55,      32'h0,       32'h0,       32'h0,       1,  2, 0, 0, 0, 3'd1, 2'd0, 2'd0, 32'h0,        32'h55,       1);
      vecs[5]  = mk("jal",   32'h55,      32'h55,      32'h0,       32'h0,       32'h0,       1,  2, 0, 1, 1, 3'd1, 2'd3, 2'd3, 32'h0,        32'h55,       31);
      vecs[6]  = mk("sra",   32'h0,       32'h80000000,32'h0,       32'h0,       32'h103,     0,  6, 0, 1, 0, 3'd2, 2'd0, 2'd0, 32'hF8000000, 32'h80000000, 6);
      vecs[7]  = mk("srav",  32'h24,      32'h80000000,32'h0,       32'h0,       32'h7,       0,  6, 0, 1, 0, 3'd2, 2'd0, 2'd0, 32'hF8000000, 32'h80000000, 6);
      vecs[8]  = mk("sltu",  32'h1,       32'hFFFFFFFF,32'h0,       32'h0,       32'h2B,      0,  8, 0, 1, 0, 3'd2, 2'd0, 2'd0, 32'h1,        32'hFFFFFFFF, 8);
      vecs[9]  = mk("slti",  32'hFFFFFFFE,32'h0,       32'h0,       32'h0,       32'hFFFFFFFF,10, 0, 1, 0, 0, 3'd7, 2'd0, 2'd0, 32'h1,        32'h0,        10);
      vecs[10] = mk("andi",  32'hFFFFFFFF,32'h0,       32'h0,       32'h0,       32'hFFFF8F0F,11, 0, 1, 0, 0, 3'd3, 2'd0, 2'd0, 32'h8F0F,     32'h0,        11);
      vecs[11] = mk("lui",   32'h0,       32'h0,       32'h0,       32'h0,       32'h1234,    12, 0, 1, 0, 0, 3'd6, 2'd0, 2'd0, 32'h12340000, 32'h0,        12);

      rst_n = 1'b0;
      drive(vecs[0]);
      #1;
      check("rst.res", o_res, 32'h0);
      check("rst.opb", o_opb, 32'h0);
      check("rst.rd", {27'd0, o_rd}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check_vec(vecs[i]);
      end

      // Unknown R-type funct (JR) gives zero.
      @(negedge clk);
      alu_op = 3'd2; imm = 32'h8; rd1 = 32'h1234; alu_src = 1'b0;
      @(posedge clk);
      #1;
      check("jr.res", o_res, 32'h0);

      // Asynchronous reset between edges, then reload on the first edge after release.
      @(negedge clk);
      drive(vecs[3]);
      @(posedge clk);
      #1;
      check("pre_rst.opb", o_opb, 32'hDEADBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.res", o_res, 32'h0);
      check("async_rst.opb", o_opb, 32'h0);
      check("async_rst.rd", {27'd0, o_rd}, 32'h0);
      #1;
      rst_n = 1'b1;
      #1;
      check("released.res", o_res, 32'h0);
      @(posedge clk);
      #1;
      check_vec(vecs[3]);

      for (int k = 0; k < 300; k++) begin
         logic [31:0] fa_v, fb_v, b_alu, e_res;
         logic [4:0]  e_rd;
         @(negedge clk);
         rd1 = $urandom; rd2 = $urandom; res_m = $urandom; rd_w = $urandom;
         imm = $urandom;
         if ($urandom_range(0, 3) != 0) imm[5:0] = legal_f[$urandom_range(0, 15)];
         rt = 5'($urandom); rd = 5'($urandom);
         alu_src = 1'($urandom); reg_dst = 1'($urandom);
         jal_sel = ($urandom_range(0, 7) == 0);
         alu_op = 3'($urandom); fwd_a = 2'($urandom); fwd_b = 2'($urandom);
         fa_v  = pick(fwd_a, rd1, rd_w, res_m);
         fb_v  = pick(fwd_b, rd2, rd_w, res_m);
         b_alu = alu_src ? imm : fb_v;
         e_res = model_res(alu_op, fa_v, b_alu, imm);
         e_rd  = jal_sel ? 5'd31 : (reg_dst ? rd : rt);
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d.res op%0d f%0d", k, alu_op, imm[5:0]), o_res, e_res);
         check($sformatf("rnd%0d.opb", k), o_opb, fb_v);
         check($sformatf("rnd%0d.rd", k), {27'd0, o_rd}, {27'd0, e_rd});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
